alu_cmp_pipe: RTL and testbench

ALU_CMP_PIPE -- requirements
Module: alu_cmp_pipe

---
 rtl/alu_cmp_pipe.sv | 146 ++++++++++++++
 tb/tb_alu_cmp_pipe.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmp_pipe.sv
// Two-stage valid/ready comparison ALU: stage A registers operands, stage B registers rd/flag.
// Define ALU_CMP_CNT_EN to add the saturating true-result counter (cnt_clr / true_cnt).
module alu_cmp_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic             flag
`ifdef ALU_CMP_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] true_cnt
`endif
);

    logic             a_valid_q, a_valid_d;
    logic [WIDTH-1:0] a_rs1_q, a_rs1_d;
    logic [WIDTH-1:0] a_rs2_q, a_rs2_d;
    logic [2:0]       a_mode_q, a_mode_d;
    logic             b_valid_q, b_valid_d;
    logic [WIDTH-1:0] b_rd_q, b_rd_d;
    logic             b_flag_q, b_flag_d;

    logic             in_xfer;
    logic             b_adv;
    logic             lt_s, lt_u, eq;
    logic             res_flag;
    logic [WIDTH-1:0] res_rd;

    assign b_adv    = !b_valid_q || out_ready;
    assign in_ready = !a_valid_q || b_adv;
    assign in_xfer  = in_valid && in_ready;

    assign out_valid = b_valid_q;
    assign rd        = b_rd_q;
    assign flag      = b_flag_q;

    // Compare/select on the stage A operands; MIN/MAX on equal operands yields rs1's value.
    always_comb begin
        lt_s     = $signed(a_rs1_q) < $signed(a_rs2_q);
        lt_u     = a_rs1_q < a_rs2_q;
        eq       = a_rs1_q == a_rs2_q;
        res_flag = 1'b0;
        res_rd   = '0;
        case (a_mode_q)
            3'b000:  res_flag = lt_s;
            3'b001:  res_flag = lt_u;
            3'b010:  res_flag = eq;
            3'b011:  res_flag = !eq;
            3'b100:  res_flag = !lt_s;
            3'b101:  res_flag = !lt_u;
            3'b110: begin
                res_flag = lt_s;
                res_rd   = lt_s ? a_rs1_q : a_rs2_q;
            end
            default: begin
                res_flag = lt_s;
                res_rd   = lt_s ? a_rs2_q : a_rs1_q;
            end
        endcase
        if (!a_mode_q[2] || !a_mode_q[1]) begin
            res_rd = {{(WIDTH-1){1'b0}}, res_flag};
        end
    end

    // Stage A refills whenever a beat is accepted; since acceptance with A full implies
    // B is advancing, A can never be overwritten before it drains.
    always_comb begin
        a_valid_d = a_valid_q;
        a_rs1_d   = a_rs1_q;
        a_rs2_d   = a_rs2_q;
        a_mode_d  = a_mode_q;
        b_valid_d = b_valid_q;
        b_rd_d    = b_rd_q;
        b_flag_d  = b_flag_q;
        if (in_xfer) begin
            a_valid_d = 1'b1;
            a_rs1_d   = rs1;
            a_rs2_d   = rs2;
            a_mode_d  = mode;
        end else if (b_adv) begin
            a_valid_d = 1'b0;
        end
        if (b_adv) begin
            b_valid_d = a_valid_q;
            if (a_valid_q) begin
                b_rd_d   = res_rd;
                b_flag_d = res_flag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            a_rs1_q   <= '0;
            a_rs2_q   <= '0;
            a_mode_q  <= '0;
            b_valid_q <= 1'b0;
            b_rd_q    <= '0;
            b_flag_q  <= 1'b0;
        end else begin
            a_valid_q <= a_valid_d;
            a_rs1_q   <= a_rs1_d;
            a_rs2_q   <= a_rs2_d;
            a_mode_q  <= a_mode_d;
            b_valid_q <= b_valid_d;
            b_rd_q    <= b_rd_d;
            b_flag_q  <= b_flag_d;
        end
    end

`ifdef ALU_CMP_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear takes priority; the count sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (b_valid_q && out_ready && b_flag_q && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign true_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_alu_cmp_pipe.sv
// Scoreboard bench for alu_cmp_pipe (WIDTH=32); the counter checks run only when ALU_CMP_CNT_EN is defined.
module tb_alu_cmp_pipe;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  rs1 = '0;
    logic [W-1:0]  rs2 = '0;
    logic [2:0]    mode = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  rd;
    logic          flag;
`ifdef ALU_CMP_CNT_EN
    logic          cnt_clr = 1'b0;
    logic [3:0]    true_cnt;
`endif

    alu_cmp_pipe #(.WIDTH(W), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .flag      (flag)
`ifdef ALU_CMP_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .true_cnt  (true_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] rd;
        logic         flag;
        int           exp_cyc;
        bit           chk_lat;
    } entry_t;

    entry_t sbq[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    bit     saw_inready_low = 0;
    bit     rand_done = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain signed/unsigned integer comparisons from the operation table.
    function automatic logic [W:0] refModel(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic f;
        logic [W-1:0] r;
        case (m)
            3'd0: f = sa < sb;
            3'd1: f = ua < ub;
            3'd2: f = ua == ub;
            3'd3: f = ua != ub;
            3'd4: f = sa >= sb;
            3'd5: f = ua >= ub;
            default: f = sa < sb;
        endcase
        if (m == 3'd6)      r = (sa <= sb) ? a : b;
        else if (m == 3'd7) r = (sa >= sb) ? a : b;
        else                r = W'(f);
        return {f, r};
    endfunction

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] m,
                                 input logic [W-1:0] exp_rd, input logic exp_flag, input bit lat);
        int n = 0;
        entry_t e;
        @(negedge clk);
        in_valid = 1'b1;
        rs1 = a;
        rs2 = b;
        mode = m;
        #1;
        while (!in_ready && n < 100) begin
            saw_inready_low = 1;
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
        end else begin
            e.rd = exp_rd;
            e.flag = exp_flag;
            e.exp_cyc = cyc + 2;
            e.chk_lat = lat;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rs1 = $urandom;
        rs2 = $urandom;
        mode = 3'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) checkOutput("drain_timeout", 64'(sbq.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pops one expectation per output transfer and checks stall stability.
    initial begin
        bit held = 0;
        logic [W-1:0] held_rd = '0;
        logic held_flag = 1'b0;
        entry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held = 0;
                continue;
            end
            if (held) begin
                checkOutput("hold_valid", 64'(out_valid), 64'd1);
                checkOutput("hold_rd", 64'(rd), 64'(held_rd));
                checkOutput("hold_flag", 64'(flag), 64'(held_flag));
            end
            held = out_valid && !out_ready;
            held_rd = rd;
            held_flag = flag;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_beat", 64'(rd), 64'hDEAD);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("rd", 64'(rd), 64'(e.rd));
                    checkOutput("flag", 64'(flag), 64'(e.flag));
                    if (e.chk_lat) checkOutput("latency", 64'(cyc), 64'(e.exp_cyc));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [W-1:0] extremes [4];
        logic [W:0] m_out;
        logic [W-1:0] a, b;
        logic [2:0] m;
        int stall_n;
        extremes[0] = 32'h8000_0000;
        extremes[1] = 32'h7FFF_FFFF;
        extremes[2] = 32'h0;
        extremes[3] = 32'hFFFF_FFFF;

        #3;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_rd", 64'(rd), 64'd0);
        checkOutput("reset_flag", 64'(flag), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        applyStimulus(32'd2, 32'd1, 3'b000, 32'd0, 1'b0, 1);
        applyStimulus(32'd1, 32'd2, 3'b000, 32'd1, 1'b1, 1);
        applyStimulus(32'd1, 32'd1, 3'b000, 32'd0, 1'b0, 1);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 3'b000, 32'd1, 1'b1, 1);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFE, 3'b000, 32'd0, 1'b0, 1);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 3'b001, 32'd0, 1'b0, 1);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 3'b101, 32'd1, 1'b1, 1);
        applyStimulus(32'd5, 32'd5, 3'b010, 32'd1, 1'b1, 1);
        applyStimulus(32'd5, 32'd5, 3'b011, 32'd0, 1'b0, 1);
        applyStimulus(32'hFFFF_FFFD, 32'hFFFF_FFFD, 3'b100, 32'd1, 1'b1, 1);
        applyStimulus(32'hFFFF_FFFB, 32'd7, 3'b110, 32'hFFFF_FFFB, 1'b1, 1);
        applyStimulus(32'hFFFF_FFFB, 32'd7, 3'b111, 32'd7, 1'b1, 1);
        applyStimulus(32'd4, 32'd4, 3'b111, 32'd4, 1'b0, 1);
        drain();

        saw_inready_low = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    applyStimulus(32'(i + 10), 32'(20 - i), 3'b111, 32'(20 - i), 1'b1, 0);
                end
            end
            begin
                stall_n = 0;
                do begin
                    @(negedge clk);
                    stall_n++;
                end while (!out_valid && stall_n < 50);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        checkOutput("stall_in_ready_fell", 64'(saw_inready_low), 64'd1);

        applyStimulus(32'd1, 32'd2, 3'b000, 32'd1, 1'b1, 0);
        applyStimulus(32'd3, 32'd2, 3'b000, 32'd0, 1'b0, 0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midreset_rd", 64'(rd), 64'd0);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        applyStimulus(32'd1, 32'd2, 3'b000, 32'd1, 1'b1, 1);
        drain();

        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    m = 3'($urandom);
                    a = $urandom;
                    b = $urandom;
                    case ($urandom_range(0, 3))
                        0: ;
                        1: b = a;
                        2: begin
                            a = extremes[$urandom_range(0, 3)];
                            b = extremes[$urandom_range(0, 3)];
                        end
                        default: begin
                            a = 32'($signed($urandom_range(0, 4)) - 2);
                            b = 32'($signed($urandom_range(0, 4)) - 2);
                        end
                    endcase
                    m_out = refModel(m, a, b);
                    applyStimulus(a, b, m, m_out[W-1:0], m_out[W], 0);
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

`ifdef ALU_CMP_CNT_EN
        @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        checkOutput("cnt_reset", 64'(true_cnt), 64'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(32'd1, 32'd2, 3'b000, 32'd1, 1'b1, 0);
        end
        drain();
        checkOutput("cnt_saturate", 64'(true_cnt), 64'd15);
        applyStimulus(32'd1, 32'd2, 3'b000, 32'd1, 1'b1, 0);
        stall_n = 0;
        do begin
            @(negedge clk);
            #1;
            stall_n++;
        end while (!out_valid && stall_n < 20);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        checkOutput("cnt_clr_wins", 64'(true_cnt), 64'd0);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
